// File: rtl/tsmac_rx_frame_drain.sv
// Read-side drain for the TSMAC RX prefetch FIFO: strips preamble/SFD, delimits frames
// onto a valid/ready byte stream and keeps saturating good/bad frame counters.
module tsmac_rx_frame_drain #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic             en,
    input  logic             cnt_clr,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_vld,
    input  logic [9:0]       fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_sop,
    output logic             m_eop,
    output logic             m_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int LEN_W = ($clog2(MAX_LEN + 2) > 11) ? $clog2(MAX_LEN + 2) : 11;
    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_LEN_W = LEN_W'(MIN_LEN);
    localparam logic [7:0]       PRE_BYTE  = 8'h55;
    localparam logic [7:0]       SFD_BYTE  = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_cnt(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             clr
    );
        logic [CNT_W-1:0] res;
        if (clr) begin
            res = {CNT_W{1'b0}};
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            res = cnt + CNT_W'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_e           state_q, state_d;
    logic             run_q;
    logic             hold_vld_q, hold_vld_d;
    logic [7:0]       hold_byte_q, hold_byte_d;
    logic             hold_sop_q, hold_sop_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             sticky_q, sticky_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_sop_q, m_sop_d;
    logic             m_eop_q, m_eop_d;
    logic             m_err_q, m_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic       word_er_s;
    logic       word_dv_s;
    logic [7:0] word_byte_s;
    logic       out_free_s;
    logic       rd_req_s;
    logic       pop_s;
    logic       frame_bad_s;
    logic       emit_s;
    logic       emit_eop_s;
    logic       emit_err_s;
    logic       frame_inc_s;
    logic       err_inc_s;

    assign word_er_s   = fifo_rd_data[9];
    assign word_dv_s   = fifo_rd_data[8];
    assign word_byte_s = fifo_rd_data[7:0];
    assign out_free_s  = !m_valid_q || m_ready;
    assign frame_bad_s = sticky_q || (len_q < MIN_LEN_W);

    // run_q keeps the pop request low while reset is asserted and for one cycle after
    assign fifo_rd_en  = run_q && rd_req_s && fifo_rd_vld;
    assign pop_s       = fifo_rd_en;

    // Per-state willingness to pop the FIFO head
    always_comb begin
        rd_req_s = 1'b0;
        case (state_q)
            ST_IDLE: rd_req_s = en;
            ST_PRE:  rd_req_s = 1'b1;
            ST_DATA: rd_req_s = out_free_s;
            ST_DROP: rd_req_s = 1'b1;
            default: rd_req_s = 1'b0;
        endcase
    end

    // Frame parser: next state, hold register, length/error tracking and emit requests
    always_comb begin
        state_d     = state_q;
        hold_vld_d  = hold_vld_q;
        hold_byte_d = hold_byte_q;
        hold_sop_d  = hold_sop_q;
        len_d       = len_q;
        sticky_d    = sticky_q;
        emit_s      = 1'b0;
        emit_eop_s  = 1'b0;
        emit_err_s  = 1'b0;
        frame_inc_s = 1'b0;
        err_inc_s   = 1'b0;
        if (pop_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!word_dv_s) begin
                        state_d = ST_IDLE;
                    end else if (word_byte_s == PRE_BYTE) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d   = ST_DROP;
                        err_inc_s = 1'b1;
                    end
                end
                ST_PRE: begin
                    if (!word_dv_s) begin
                        state_d   = ST_IDLE;
                        err_inc_s = 1'b1;
                    end else if (word_byte_s == PRE_BYTE) begin
                        state_d = ST_PRE;
                    end else if (word_byte_s == SFD_BYTE) begin
                        state_d    = ST_DATA;
                        len_d      = {LEN_W{1'b0}};
                        sticky_d   = 1'b0;
                        hold_vld_d = 1'b0;
                    end else begin
                        state_d   = ST_DROP;
                        err_inc_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (word_dv_s) begin
                        if (len_q == MAX_LEN_W) begin
                            // Oversize: the new byte is discarded and the held one closes the frame
                            emit_s     = 1'b1;
                            emit_eop_s = 1'b1;
                            emit_err_s = 1'b1;
                            err_inc_s  = 1'b1;
                            hold_vld_d = 1'b0;
                            state_d    = ST_DROP;
                        end else begin
                            emit_s      = hold_vld_q;
                            hold_vld_d  = 1'b1;
                            hold_byte_d = word_byte_s;
                            hold_sop_d  = !hold_vld_q;
                            len_d       = len_q + LEN_W'(1);
                            sticky_d    = sticky_q || word_er_s;
                        end
                    end else begin
                        if (hold_vld_q) begin
                            emit_s      = 1'b1;
                            emit_eop_s  = 1'b1;
                            emit_err_s  = frame_bad_s;
                            frame_inc_s = !frame_bad_s;
                            err_inc_s   = frame_bad_s;
                        end else begin
                            err_inc_s = 1'b1;
                        end
                        hold_vld_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!word_dv_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_vld_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output register and statistics counters
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sop_d   = m_sop_q;
        m_eop_d   = m_eop_q;
        m_err_d   = m_err_q;
        if (emit_s) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_byte_q;
            m_sop_d   = hold_sop_q;
            m_eop_d   = emit_eop_s;
            m_err_d   = emit_err_s;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
        frame_cnt_d = sat_cnt(frame_cnt_q, frame_inc_s, cnt_clr);
        err_cnt_d   = sat_cnt(err_cnt_q, err_inc_s, cnt_clr);
    end

    // State and datapath registers
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_byte_q <= 8'h00;
            hold_sop_q  <= 1'b0;
            len_q       <= {LEN_W{1'b0}};
            sticky_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= 8'h00;
            m_sop_q     <= 1'b0;
            m_eop_q     <= 1'b0;
            m_err_q     <= 1'b0;
            frame_cnt_q <= {CNT_W{1'b0}};
            err_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            hold_vld_q  <= hold_vld_d;
            hold_byte_q <= hold_byte_d;
            hold_sop_q  <= hold_sop_d;
            len_q       <= len_d;
            sticky_q    <= sticky_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_sop_q     <= m_sop_d;
            m_eop_q     <= m_eop_d;
            m_err_q     <= m_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_sop     = m_sop_q;
    assign m_eop     = m_eop_q;
    assign m_err     = m_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tsmac_rx_frame_drain.sv
// Bench for tsmac_rx_frame_drain: a queue-backed FIFO feeds random frames; a stream-level
// frame model predicts the beats and counters that the scoreboard checks.
module tb_tsmac_rx_frame_drain;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int CNT_W   = 16;

    logic             rd_clk = 1'b0;
    logic             rd_rst_n;
    logic             en;
    logic             cnt_clr;
    logic             fifo_rd_en;
    logic             fifo_rd_vld;
    logic [9:0]       fifo_rd_data;
    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_data;
    logic             m_sop;
    logic             m_eop;
    logic             m_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    tsmac_rx_frame_drain #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .en(en), .cnt_clr(cnt_clr),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop),
        .m_eop(m_eop), .m_err(m_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } beat_t;

    logic [9:0] fifo_q[$];
    beat_t      exp_q[$];
    int         exp_frames = 0;
    int         exp_errs   = 0;
    int         n_tests    = 0;
    int         n_fail     = 0;

    // Reference: classify one dv=1 burst as a whole frame
    task automatic model_burst(input logic [9:0] b[$]);
        int    p;
        int    plen;
        bit    bad;
        beat_t bt;
        p = 0;
        while (p < b.size() && b[p][7:0] == 8'h55) p++;
        if (p == 0 || p == b.size() || b[p][7:0] != 8'hD5) begin
            exp_errs++;
        end else begin
            plen = b.size() - p - 1;
            if (plen == 0) begin
                exp_errs++;
            end else if (plen > MAX_LEN) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    bt.data = b[p+1+k][7:0];
                    bt.sop  = (k == 0);
                    bt.eop  = (k == MAX_LEN - 1);
                    bt.err  = (k == MAX_LEN - 1);
                    exp_q.push_back(bt);
                end
                exp_errs++;
            end else begin
                bad = (plen < MIN_LEN);
                for (int k = 0; k < plen; k++) if (b[p+1+k][9]) bad = 1'b1;
                for (int k = 0; k < plen; k++) begin
                    bt.data = b[p+1+k][7:0];
                    bt.sop  = (k == 0);
                    bt.eop  = (k == plen - 1);
                    bt.err  = (k == plen - 1) && bad;
                    exp_q.push_back(bt);
                end
                if (bad) exp_errs++;
                else exp_frames++;
            end
        end
    endtask

    task automatic model_stream(input logic [9:0] w[$]);
        logic [9:0] burst[$];
        int         i;
        i = 0;
        while (i < w.size()) begin
            if (w[i][8] == 1'b0) begin
                i++;
            end else begin
                burst.delete();
                while (i < w.size() && w[i][8] == 1'b1) begin
                    burst.push_back(w[i]);
                    i++;
                end
                model_burst(burst);
            end
        end
    endtask

    task automatic push_frame(input int npre, input bit has_sfd, input logic [7:0] sfd,
                              input int plen, input int er_idx, input bit rnd, input int gaps);
        logic [7:0] byte_v;
        for (int k = 0; k < npre; k++) fifo_q.push_back({2'b01, 8'h55});
        if (has_sfd) begin
            fifo_q.push_back({2'b01, sfd});
            for (int k = 0; k < plen; k++) begin
                byte_v = rnd ? 8'($urandom) : 8'(k);
                fifo_q.push_back({(k == er_idx), 1'b1, byte_v});
            end
        end
        fifo_q.push_back({2'b00, 8'h00});
        for (int k = 0; k < gaps; k++) fifo_q.push_back({2'b00, 8'($urandom)});
    endtask

    // Drives the FIFO side and downstream ready, and scoreboards every accepted beat
    task automatic run_stream(input int ready_mode, input int gap_pct, input int keep,
                              input int en_off_at, input int rst_at, input bit clr_on_term,
                              input int win_lo, input int win_hi, input int budget);
        int         cyc;
        int         popped;
        bit         have_prev;
        bit         rst_done;
        bit         clr_hit;
        logic [11:0] prev_v;
        logic [11:0] cur_v;
        logic       pop;
        logic       acc;
        beat_t      act;
        beat_t      exp_b;
        cyc = 0; popped = 0; have_prev = 1'b0; rst_done = 1'b0; prev_v = '0;
        while (((fifo_q.size() > keep) || (exp_q.size() > 0)) && (cyc < budget)) begin
            @(negedge rd_clk);
            cyc++;
            cnt_clr = 1'b0;
            clr_hit = 1'b0;
            if (en_off_at >= 0 && popped >= en_off_at) en = 1'b0;
            if (rst_at >= 0 && !rst_done && popped >= rst_at) begin
                rst_done     = 1'b1;
                have_prev    = 1'b0;
                rd_rst_n     = 1'b0;
                fifo_rd_vld  = (fifo_q.size() > 0);
                fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 10'h000;
                m_ready      = 1'b1;
                for (int c = 0; c < 2; c++) begin
                    #1;
                    n_tests++;
                    if ({fifo_rd_en, m_valid, m_data, m_sop, m_eop, m_err, frame_cnt, err_cnt} !== '0) begin
                        n_fail++;
                        $display("FAIL mid_reset_outputs: rd_en=%0b valid=%0b data=%02h sop=%0b eop=%0b err=%0b fcnt=%0d ecnt=%0d, required all 0",
                                 fifo_rd_en, m_valid, m_data, m_sop, m_eop, m_err, frame_cnt, err_cnt);
                    end
                    @(negedge rd_clk);
                end
                rd_rst_n = 1'b1;
                exp_q.delete();
                exp_frames = 0;
                exp_errs   = 0;
                model_stream(fifo_q);
            end else begin
                fifo_rd_vld  = (fifo_q.size() > 0) && ($urandom_range(99) >= gap_pct);
                fifo_rd_data = fifo_rd_vld ? fifo_q[0] : 10'($urandom);
                case (ready_mode)
                    0:       m_ready = 1'b1;
                    1:       m_ready = cyc[0];
                    default: m_ready = 1'($urandom_range(1));
                endcase
                #1;
                n_tests++;
                if (fifo_rd_en && !fifo_rd_vld) begin
                    n_fail++;
                    $display("FAIL rd_en_without_vld: rd_en=1 vld=0 at cycle %0d", cyc);
                end
                cur_v = {m_valid, m_data, m_sop, m_eop, m_err};
                if (have_prev) begin
                    n_tests++;
                    if (cur_v !== prev_v) begin
                        n_fail++;
                        $display("FAIL stall_hold: outputs %03h, required held %03h", cur_v, prev_v);
                    end
                end
                have_prev = m_valid && !m_ready;
                prev_v    = cur_v;
                if (popped >= win_lo && popped <= win_hi && m_valid && !m_ready) begin
                    n_tests++;
                    if (fifo_rd_en !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_no_pop: rd_en=%0b while stalled in payload, required 0", fifo_rd_en);
                    end
                end
                pop = fifo_rd_en && fifo_rd_vld;
                acc = m_valid && m_ready;
                if (clr_on_term && pop && fifo_q.size() == 1 && !fifo_q[0][8]) begin
                    cnt_clr = 1'b1;
                    clr_hit = 1'b1;
                end
                @(posedge rd_clk);
                if (pop) begin
                    void'(fifo_q.pop_front());
                    popped++;
                end
                if (acc) begin
                    n_tests++;
                    act.data = m_data;
                    act.sop  = m_sop;
                    act.eop  = m_eop;
                    act.err  = m_eop & m_err;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: data=%02h sop=%0b eop=%0b, required no beat", m_data, m_sop, m_eop);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (act !== exp_b) begin
                            n_fail++;
                            $display("FAIL beat: got data=%02h sop=%0b eop=%0b err=%0b, required data=%02h sop=%0b eop=%0b err=%0b",
                                     act.data, act.sop, act.eop, act.err, exp_b.data, exp_b.sop, exp_b.eop, exp_b.err);
                        end
                    end
                end
                if (clr_hit) begin
                    exp_frames = 0;
                    exp_errs   = 0;
                end
            end
        end
        n_tests++;
        if (cyc >= budget) begin
            n_fail++;
            $display("FAIL stream_timeout: %0d words and %0d beats left after %0d cycles, required 0",
                     fifo_q.size(), exp_q.size(), cyc);
        end
        @(negedge rd_clk);
        cnt_clr = 1'b0;
        fifo_rd_vld = 1'b0;
        #1;
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trailing_valid: m_valid=%0b after stream, required 0", m_valid);
        end
    endtask

    task automatic test_reset();
        rd_rst_n = 1'b0; en = 1'b1; cnt_clr = 1'b0; m_ready = 1'b1;
        fifo_rd_vld = 1'b1; fifo_rd_data = {2'b01, 8'h55};
        @(negedge rd_clk);
        @(negedge rd_clk);
        n_tests++;
        if ({fifo_rd_en, m_valid, m_data, m_sop, m_eop, m_err, frame_cnt, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rd_en=%0b valid=%0b data=%02h fcnt=%0d ecnt=%0d, required all 0",
                     fifo_rd_en, m_valid, m_data, frame_cnt, err_cnt);
        end
        fifo_rd_vld = 1'b0;
        rd_rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        push_frame(7, 1'b1, 8'hD5, 64, -1, 1'b0, 0);
        model_stream(fifo_q);
        run_stream(0, 0, 0, -1, -1, 1'b0, -1, -2, 2000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {16'd1, 16'd0}) begin
            n_fail++;
            $display("FAIL good_frame_cnt: frame=%0d err=%0d, required 1 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_short_and_err_frames();
        push_frame(7, 1'b1, 8'hD5, 10, -1, 1'b0, 0);
        push_frame(7, 1'b1, 8'hD5, 63, -1, 1'b1, 1);
        push_frame(7, 1'b1, 8'hD5, 64, 20, 1'b0, 0);
        model_stream(fifo_q);
        run_stream(0, 0, 0, -1, -1, 1'b0, -1, -2, 2000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {CNT_W'(exp_frames), CNT_W'(exp_errs)}) begin
            n_fail++;
            $display("FAIL short_err_cnt: frame=%0d err=%0d, required %0d %0d", frame_cnt, err_cnt, exp_frames, exp_errs);
        end
    endtask

    task automatic test_truncation();
        push_frame(7, 1'b1, 8'hD5, 1600, -1, 1'b1, 0);
        push_frame(7, 1'b1, 8'hD5, MAX_LEN, -1, 1'b1, 0);
        push_frame(7, 1'b1, 8'hD5, 64, -1, 1'b0, 0);
        model_stream(fifo_q);
        run_stream(0, 0, 0, -1, -1, 1'b0, -1, -2, 8000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {CNT_W'(exp_frames), CNT_W'(exp_errs)}) begin
            n_fail++;
            $display("FAIL trunc_cnt: frame=%0d err=%0d, required %0d %0d", frame_cnt, err_cnt, exp_frames, exp_errs);
        end
    endtask

    task automatic test_backpressure();
        push_frame(7, 1'b1, 8'hD5, 64, -1, 1'b0, 0);
        model_stream(fifo_q);
        run_stream(1, 0, 0, -1, -1, 1'b0, 8, 72, 2000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {CNT_W'(exp_frames), CNT_W'(exp_errs)}) begin
            n_fail++;
            $display("FAIL bp_cnt: frame=%0d err=%0d, required %0d %0d", frame_cnt, err_cnt, exp_frames, exp_errs);
        end
    endtask

    task automatic test_random_frames();
        int kind;
        int plen;
        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 6);
            plen = $urandom_range(1, 200);
            case (kind)
                0, 1:    push_frame($urandom_range(1, 8), 1'b1, 8'hD5, plen, -1, 1'b1, $urandom_range(0, 3));
                2:       push_frame($urandom_range(1, 8), 1'b1, 8'hD5, plen, $urandom_range(0, plen - 1), 1'b1, 1);
                3:       push_frame($urandom_range(0, 4), 1'b1, 8'h3C, 20, -1, 1'b1, 0);
                4:       push_frame($urandom_range(1, 8), 1'b0, 8'h00, 0, -1, 1'b1, 2);
                5:       push_frame($urandom_range(1, 8), 1'b1, 8'hD5, 0, -1, 1'b1, 0);
                default: push_frame(0, 1'b1, 8'hD5, 30, -1, 1'b1, 1);
            endcase
        end
        model_stream(fifo_q);
        run_stream(2, 25, 0, -1, -1, 1'b0, -1, -2, 20000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {CNT_W'(exp_frames), CNT_W'(exp_errs)}) begin
            n_fail++;
            $display("FAIL random_cnt: frame=%0d err=%0d, required %0d %0d", frame_cnt, err_cnt, exp_frames, exp_errs);
        end
    endtask

    task automatic test_en_stop();
        int sz_a;
        int sz_b;
        push_frame(7, 1'b1, 8'hD5, 64, -1, 1'b0, 0);
        model_stream(fifo_q);
        sz_a = fifo_q.size();
        push_frame(7, 1'b1, 8'hD5, 70, -1, 1'b1, 0);
        sz_b = fifo_q.size() - sz_a;
        run_stream(0, 0, sz_b, 20, -1, 1'b0, -1, -2, 2000);
        n_tests++;
        if (fifo_q.size() !== sz_b) begin
            n_fail++;
            $display("FAIL en_stop_words: %0d words left, required %0d", fifo_q.size(), sz_b);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge rd_clk);
            fifo_rd_vld  = 1'b1;
            fifo_rd_data = fifo_q[0];
            #1;
            n_tests++;
            if (fifo_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL en_stop_idle: rd_en=%0b with en=0 and vld=1, required 0", fifo_rd_en);
            end
        end
        en = 1'b1;
        model_stream(fifo_q);
        run_stream(2, 10, 0, -1, -1, 1'b0, -1, -2, 2000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {CNT_W'(exp_frames), CNT_W'(exp_errs)}) begin
            n_fail++;
            $display("FAIL en_stop_cnt: frame=%0d err=%0d, required %0d %0d", frame_cnt, err_cnt, exp_frames, exp_errs);
        end
    endtask

    task automatic test_cnt_clr();
        push_frame(7, 1'b1, 8'hD5, 64, -1, 1'b1, 0);
        model_stream(fifo_q);
        run_stream(0, 0, 0, -1, -1, 1'b1, -1, -2, 2000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {CNT_W'(exp_frames), CNT_W'(exp_errs)} || exp_frames != 0) begin
            n_fail++;
            $display("FAIL cnt_clr: frame=%0d err=%0d, required 0 0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        push_frame(7, 1'b1, 8'hD5, 64, -1, 1'b0, 0);
        push_frame(7, 1'b1, 8'hD5, 80, -1, 1'b1, 0);
        model_stream(fifo_q);
        run_stream(0, 0, 0, -1, 30, 1'b0, -1, -2, 2000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL reset_resume_cnt: frame=%0d err=%0d, required 1 1", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) push_frame(7, 1'b1, 8'hD5, $urandom_range(64, 100), -1, 1'b1, 0);
        model_stream(fifo_q);
        run_stream(0, 0, 0, -1, -1, 1'b0, -1, -2, 2000);
        n_tests++;
        if ({frame_cnt, err_cnt} !== {CNT_W'(exp_frames), CNT_W'(exp_errs)}) begin
            n_fail++;
            $display("FAIL b2b_cnt: frame=%0d err=%0d, required %0d %0d", frame_cnt, err_cnt, exp_frames, exp_errs);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_and_err_frames();
        test_truncation();
        test_backpressure();
        test_random_frames();
        test_en_stop();
        test_cnt_clr();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tsmac_rx_frame_drain.md
Name: tsmac_rx_frame_drain

Overview:
- Read-side controller for the TSMAC RX clock-domain-crossing prefetch FIFO. FIFO words are 10 bits: bit9 = rx_er, bit8 = rx_dv, bits 7:0 = byte.
- Pops the FIFO through its rd_en/rd_vld handshake, strips preamble and SFD, and delimits frames.
- Emits a byte stream with sop/eop/err flags to the MAC RX parser over valid/ready.
- Enforces min/max frame length and keeps saturating frame and error counters.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes after SFD; shorter frames are flagged err.
- MAX_LEN, 1518, maximum length; byte MAX_LEN+1 triggers truncation.
- CNT_W, 16, width of the statistics counters.

Ports:
- rd_clk  in  1  single clock (FIFO read-side clock).
- rd_rst_n  in  1  asynchronous active-low reset.
- en  in  1  drain enable; sampled only in IDLE.
- cnt_clr  in  1  synchronous pulse that clears both counters.
- fifo_rd_en  out  1  pop request to the prefetch FIFO.
- fifo_rd_vld  in  1  FIFO head word valid.
- fifo_rd_data  in  10  FIFO head word.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accept.
- m_data  out  8  frame byte.
- m_sop  out  1  first byte of frame.
- m_eop  out  1  last byte of frame.
- m_err  out  1  frame error; qualified by m_eop.
- frame_cnt  out  CNT_W  good frames, saturating.
- err_cnt  out  CNT_W  bad or dropped frames, saturating.

Behaviour:
- Reset: state = IDLE; hold register empty; m_valid/m_sop/m_eop/m_err/m_data = 0; counters = 0; fifo_rd_en = 0.
- pop = fifo_rd_en & fifo_rd_vld. fifo_rd_en is combinational and never asserts without fifo_rd_vld.
- out_free = !m_valid | m_ready.
- fifo_rd_en per state: IDLE requires en; PRE and DROP pop unconditionally; DATA requires out_free.
- Output register: loaded on an emit. Otherwise m_valid clears on m_ready. m_* stay stable while m_valid & !m_ready.
- A one-byte hold register {byte, sop flag} delays each byte by one word so the eop can be attached to the last byte.
- An error sticky bit and a length counter (11 bits minimum) track the current frame.
- IDLE:
  - dv=0 -> stay.
  - dv=1 & byte==0x55 -> PRE.
  - dv=1 & any other byte -> DROP, err_cnt+1.
  - en=0 -> no pop; stops only at a frame boundary.
- PRE:
  - 0x55 -> stay.
  - 0xD5 -> DATA; len=0; sticky=0; next byte is marked sop.
  - dv=0 -> IDLE, err_cnt+1.
  - any other byte -> DROP, err_cnt+1.
- DATA, dv=1:
  - If hold is full, emit hold with eop=0.
  - Load the new byte into hold; len+1; sticky |= er.
  - If the new byte would be byte MAX_LEN+1: discard it, emit hold with eop=1, err=1, err_cnt+1 -> DROP.
- DATA, dv=0:
  - If hold is full, emit hold with eop=1, err = sticky | (len<MIN_LEN). Increment frame_cnt if err=0, else err_cnt.
  - If hold is empty (SFD immediately followed by dv=0), emit nothing; err_cnt+1.
  - -> IDLE.
- DROP: pop until dv=0 -> IDLE. Nothing is emitted.
- Latency: a byte popped in cycle N appears on m_data in cycle M+1, where M is the cycle in which the following word is popped.
- Counters: stick at 2^CNT_W-1. When cnt_clr and an increment coincide, cnt_clr wins.
- FIFO empty mid-frame: the controller waits in its current state with no timeout. Hold and output are preserved.
- Back-pressure: m_ready=0 stalls popping in DATA only. The FIFO absorbs the stall; overflow is the write side's concern.
- Asynchronous reset mid-frame: returns to IDLE immediately. The next word is parsed as the start of a new frame, so leftover frame bytes go IDLE -> DROP.

Test Plan:
- Frame: 7×0x55, 0xD5, 64 bytes 0x00..0x3F, then dv=0; m_ready=1 -> 64 beats; sop on 0x00, eop on 0x3F, err=0; frame_cnt=1.
- Same frame with 10 bytes only -> 10 beats, eop err=1; err_cnt=1, frame_cnt=0.
- 64-byte frame with er=1 on byte 20 -> eop err=1; err_cnt=1.
- 1600-byte frame -> 1518 beats; eop+err on byte 1518; DROP discards the rest; err_cnt=1. The next good frame is received cleanly.
- m_ready toggling 1/0 each cycle during a 64-byte frame -> data is identical to the first test; fifo_rd_en stays 0 on stalled cycles.
- en=0 asserted mid-frame -> the current frame completes, then fifo_rd_en=0 with fifo_rd_vld=1.
- cnt_clr pulsed together with an eop -> counters read 0.
- rd_rst_n low for 2 cycles mid-frame -> all outputs 0. Resumes correctly on the next preamble.
